// File: rtl/ttl_buffer_fifo.sv
// WIDTH-bit, GROUPS-way 3-state line driver fed from a DEPTH-entry FIFO.
// Each group has its own active-low enable. The head word, or the last word popped once the FIFO is empty, drives the bus.
module ttl_buffer_fifo #(
    parameter int WIDTH  = 8,
    parameter int GROUPS = 2,
    parameter int DEPTH  = 4,
    localparam int GW    = WIDTH / GROUPS,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  a,
    input  logic              load,
    input  logic              pop,
    input  logic [GROUPS-1:0] g_n,
    output wire  [WIDTH-1:0]  y,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clear_err
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             wr_en_s, rd_en_s;
    logic [WIDTH-1:0] d_s;

    // Next-state logic. While the FIFO is full, a pop frees the slot that the same-cycle write uses.
    always_comb begin
        rd_en_s  = pop && !empty_q;
        wr_en_s  = load && (!full_q || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        hold_d   = hold_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            hold_d   = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            hold_d   = hold_q;
        end
        count_d = count_q + CW'(wr_en_s) - CW'(rd_en_s);
        empty_d = (count_d == CW'(0));
        full_d  = (count_d == CW'(DEPTH));
        // A new error in the same cycle as clear_err takes priority over the clear.
        if (load && full_q && !pop) begin
            ovf_d = 1'b1;
        end else if (clear_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (pop && empty_q) begin
            unf_d = 1'b1;
        end else if (clear_err) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    // Pointer, occupancy and flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            hold_q   <= hold_d;
        end
    end

    // FIFO storage holds no reset state; the reset pointers and flags make old entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= a;
        end
    end

    assign d_s = empty_q ? hold_q : mem_q[rd_ptr_q];

    for (genvar k = 0; k < GROUPS; k++) begin : g_drv
        assign y[k*GW +: GW] = g_n[k] ? {GW{1'bz}} : d_s[k*GW +: GW];
    end

    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_ttl_buffer_fifo.sv
// Directed bench for ttl_buffer_fifo (WIDTH=8, GROUPS=2, DEPTH=4).
// The bus has a pull-up, so a disabled group reads as all ones.
module tb_ttl_buffer_fifo;

    typedef struct {
        logic       ld;
        logic       pp;
        logic       clr;
        logic [7:0] a;
        logic [1:0] gn;
        logic [7:0] y;
        logic [2:0] cnt;
        logic       emp;
        logic       ful;
        logic       ovf;
        logic       unf;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a = 8'h00;
    logic       load = 1'b0;
    logic       pop = 1'b0;
    logic [1:0] g_n = 2'b00;
    logic       clear_err = 1'b0;
    tri1  [7:0] y;
    logic       empty, full, overflow, underflow;
    logic [2:0] count;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vt [17];
    logic [7:0] q [$];
    logic [7:0] popped;

    ttl_buffer_fifo #(.WIDTH(8), .GROUPS(2), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .a(a), .load(load), .pop(pop), .g_n(g_n),
        .y(y), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .underflow(underflow), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic ld, input logic pp, input logic clr,
                                input logic [7:0] av, input logic [1:0] gn,
                                input logic [7:0] ey, input logic [2:0] ec,
                                input logic ee, input logic ef,
                                input logic eo, input logic eu);
        vec_t v;
        v.ld = ld; v.pp = pp; v.clr = clr; v.a = av; v.gn = gn;
        v.y = ey; v.cnt = ec; v.emp = ee; v.ful = ef; v.ovf = eo; v.unf = eu;
        return v;
    endfunction

    initial begin
        //          ld    pp    clr   a      gn     y      cnt   emp   ful   ovf   unf
        vt[0]  = mk(1'b1, 1'b0, 1'b0, 8'hA5, 2'b10, 8'hF5, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[1]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 2'b01, 8'hAF, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[2]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 8'hA5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[3]  = mk(1'b1, 1'b0, 1'b0, 8'h11, 2'b00, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[4]  = mk(1'b1, 1'b0, 1'b0, 8'h22, 2'b00, 8'h11, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[5]  = mk(1'b1, 1'b0, 1'b0, 8'h33, 2'b00, 8'h11, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[6]  = mk(1'b1, 1'b0, 1'b0, 8'h44, 2'b00, 8'h11, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        vt[7]  = mk(1'b1, 1'b0, 1'b0, 8'h55, 2'b00, 8'h11, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        vt[8]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 8'h22, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[9]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 8'h33, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[10] = mk(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 8'h44, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[11] = mk(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 8'h44, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[12] = mk(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 8'h44, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        vt[13] = mk(1'b0, 1'b0, 1'b1, 8'h00, 2'b00, 8'h44, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[14] = mk(1'b0, 1'b1, 1'b1, 8'h00, 2'b00, 8'h44, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        vt[15] = mk(1'b0, 1'b0, 1'b1, 8'h00, 2'b11, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[16] = mk(1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset state
        #12;
        chk("rst_y_en", y, 8'h00);
        chk("rst_empty", empty, 1'b1);
        chk("rst_count", count, 3'd0);
        chk("rst_full", full, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_unf", underflow, 1'b0);
        g_n = 2'b11;
        #1;
        chk("rst_y_dis", y, 8'hFF);
        g_n = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 17; i++) begin
            load = vt[i].ld; pop = vt[i].pp; clear_err = vt[i].clr;
            a = vt[i].a; g_n = vt[i].gn;
            tick();
            chk($sformatf("v%0d_y", i), y, vt[i].y);
            chk($sformatf("v%0d_count", i), count, vt[i].cnt);
            chk($sformatf("v%0d_empty", i), empty, vt[i].emp);
            chk($sformatf("v%0d_full", i), full, vt[i].ful);
            chk($sformatf("v%0d_ovf", i), overflow, vt[i].ovf);
            chk($sformatf("v%0d_unf", i), underflow, vt[i].unf);
        end

        // Fill to full, then run ten simultaneous load+pop cycles across the pointer wrap
        load = 1'b0; pop = 1'b0; clear_err = 1'b1; g_n = 2'b00;
        tick();
        clear_err = 1'b0;
        q = '{8'h00};
        for (int i = 1; i < 4; i++) begin
            load = 1'b1; a = 8'(i);
            tick();
            q.push_back(8'(i));
        end
        chk("fill_full", full, 1'b1);
        chk("fill_count", count, 3'd4);
        for (int i = 0; i < 10; i++) begin
            load = 1'b1; pop = 1'b1; a = 8'h60 + 8'(i);
            tick();
            void'(q.pop_front());
            q.push_back(8'h60 + 8'(i));
            chk($sformatf("wrap%0d_y", i), y, q[0]);
            chk($sformatf("wrap%0d_count", i), count, 3'd4);
            chk($sformatf("wrap%0d_ovf", i), overflow, 1'b0);
        end
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1;
            popped = q.pop_front();
            tick();
            chk($sformatf("drain%0d_y", i), y, (q.size() != 0) ? q[0] : popped);
            chk($sformatf("drain%0d_count", i), count, 3'(q.size()));
        end
        pop = 1'b0;
        chk("drain_empty", empty, 1'b1);

        // Reset asserted between edges with three entries queued
        for (int i = 0; i < 3; i++) begin
            load = 1'b1; a = 8'hC0 + 8'(i);
            tick();
        end
        load = 1'b0;
        chk("pre_rst_count", count, 3'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_count", count, 3'd0);
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_y", y, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        tick();
        load = 1'b1; a = 8'h77;
        tick();
        load = 1'b0;
        chk("post_rst_y", y, 8'h77);
        chk("post_rst_count", count, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
